// File: rtl/song_progress_bar.sv
// Song progress bar: beat counter driving a thermometer LED row via a division-free segment accumulator.
// Optional build macro SONG_PROGRESS_BLINK_EN adds frontier/pause blinking.
//
// state    | meaning
// S_IDLE   | no song; bar dark
// S_PLAY   | counting beats; bar shows progress
// S_PAUSED | progress held while i_pause is high
// S_DONE   | song finished; bar full
module song_progress_bar #(
  parameter int NUM_LEDS  = 10,
  parameter int CNT_W     = 8,
  parameter int BLINK_DIV = 22
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_pause,
  input  logic                i_beat,
  input  logic [CNT_W-1:0]    i_song_len,
  output logic [NUM_LEDS-1:0] o_prog,
  output logic [CNT_W-1:0]    o_beat_cnt,
  output logic                o_busy,
  output logic                o_done
);

  localparam int ACC_W = CNT_W + $clog2(NUM_LEDS) + 1;
  localparam int SEG_W = $clog2(NUM_LEDS + 1);
  localparam logic [CNT_W-1:0] LEDS_C = CNT_W'(NUM_LEDS);
  localparam logic [ACC_W-1:0] LEDS_A = ACC_W'(NUM_LEDS);

  if (NUM_LEDS < 2 || NUM_LEDS > (1 << CNT_W) - 1 || BLINK_DIV < 1) begin : g_param_check
    $error("song_progress_bar: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PLAY   = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_len;
  logic [CNT_W-1:0]    r_cnt;
  logic [ACC_W-1:0]    r_acc;
  logic [SEG_W-1:0]    r_seg;
  logic [NUM_LEDS-1:0] r_bar;

  logic [CNT_W-1:0]    w_len_clamp;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic [ACC_W-1:0]    w_acc_sum;
  logic [ACC_W-1:0]    w_acc_nxt;
  logic [SEG_W-1:0]    w_seg_inc;
  logic [SEG_W-1:0]    w_seg_d;
  logic [NUM_LEDS-1:0] w_bar_d;
  logic                w_beat_ok;
  logic                w_last;

  function automatic logic [NUM_LEDS-1:0] f_therm(input logic [SEG_W-1:0] seg);
    logic [NUM_LEDS-1:0] bar;
    bar = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      bar[i] = (i <= int'(seg));
    end
    return bar;
  endfunction

  assign w_len_clamp = (i_song_len < LEDS_C) ? LEDS_C : i_song_len;
  // start and pause both outrank a beat in the same cycle
  assign w_beat_ok   = (r_state == S_PLAY) && i_beat && !i_pause && !i_start;
  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_last      = w_beat_ok && (w_cnt_inc == r_len);

  // len >= NUM_LEDS, so a single conditional subtract keeps acc below len
  always_comb begin
    w_acc_sum = r_acc + LEDS_A;
    w_acc_nxt = w_acc_sum;
    w_seg_inc = r_seg;
    if (w_acc_sum >= ACC_W'(r_len)) begin
      w_acc_nxt = w_acc_sum - ACC_W'(r_len);
      w_seg_inc = r_seg + 1'b1;
    end
  end

  always_comb begin
    w_seg_d = r_seg;
    if (i_start) begin
      w_seg_d = '0;
    end else if (w_beat_ok) begin
      w_seg_d = w_seg_inc;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_start) begin
      w_state_nxt = S_PLAY;
    end else begin
      case (r_state)
        S_PLAY: begin
          if (i_pause) begin
            w_state_nxt = S_PAUSED;
          end else if (w_last) begin
            w_state_nxt = S_DONE;
          end
        end
        S_PAUSED: begin
          if (!i_pause) begin
            w_state_nxt = S_PLAY;
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    case (w_state_nxt)
      S_IDLE:  w_bar_d = '0;
      S_DONE:  w_bar_d = '1;
      default: w_bar_d = f_therm(w_seg_d);
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_len <= '0;
      r_cnt <= '0;
      r_acc <= '0;
      r_seg <= '0;
      r_bar <= '0;
    end else begin
      r_bar <= w_bar_d;
      if (i_start) begin
        r_len <= w_len_clamp;
        r_cnt <= '0;
        r_acc <= '0;
        r_seg <= '0;
      end else if (w_beat_ok) begin
        r_cnt <= w_cnt_inc;
        r_acc <= w_acc_nxt;
        r_seg <= w_seg_inc;
      end
    end
  end

`ifdef SONG_PROGRESS_BLINK_EN
  logic [BLINK_DIV:0]  r_blink;
  logic [NUM_LEDS-1:0] w_front;
  logic                w_blink_on;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_blink <= '0;
    end else if (i_start) begin
      r_blink <= '0;
    end else if (r_state == S_PLAY || r_state == S_PAUSED) begin
      r_blink <= r_blink + 1'b1;
    end
  end

  assign w_front    = r_bar & ~(r_bar >> 1);
  assign w_blink_on = r_blink[BLINK_DIV];
`endif

  always_comb begin
    o_busy     = (r_state == S_PLAY) || (r_state == S_PAUSED);
    o_done     = (r_state == S_DONE);
    o_beat_cnt = r_cnt;
    o_prog     = r_bar;
`ifdef SONG_PROGRESS_BLINK_EN
    if (!w_blink_on) begin
      if (r_state == S_PLAY) begin
        o_prog = r_bar & ~w_front;
      end else if (r_state == S_PAUSED) begin
        o_prog = '0;
      end
    end
`endif
  end

endmodule

// File: tb/tb_song_progress_bar.sv
// Scoreboard bench for song_progress_bar: a behavioural model computes the bar by
// direct division and queues expected outputs for comparison after each edge.
module tb_song_progress_bar;

  localparam int N  = 10;
  localparam int CW = 8;
  localparam int BD = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          pause;
  logic          beat;
  logic [CW-1:0] song_len;
  logic [N-1:0]  prog;
  logic [CW-1:0] beat_cnt;
  logic          busy;
  logic          done;

  song_progress_bar #(
    .NUM_LEDS (N),
    .CNT_W    (CW),
    .BLINK_DIV(BD)
  ) u_dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_pause   (pause),
    .i_beat    (beat),
    .i_song_len(song_len),
    .o_prog    (prog),
    .o_beat_cnt(beat_cnt),
    .o_busy    (busy),
    .o_done    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  prog;
    logic [CW-1:0] cnt;
    logic          busy;
    logic          done;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // model: 0 idle, 1 play, 2 paused, 3 done
  int m_state = 0;
  int m_cnt   = 0;
  int m_len   = 0;
  int m_blk   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [N-1:0] model_prog();
    logic [N-1:0] p;
    int lit;
    p = '0;
    lit = 0;
    if (m_state == 3) begin
      p = '1;
    end else if (m_state != 0) begin
      lit = (m_cnt * N) / m_len + 1;
      if (lit > N) lit = N;
      for (int i = 0; i < lit; i++) p[i] = 1'b1;
`ifdef SONG_PROGRESS_BLINK_EN
      if (((m_blk >> BD) & 1) == 0) begin
        if (m_state == 1) p[lit-1] = 1'b0;
        else p = '0;
      end
`endif
    end
    return p;
  endfunction

  task automatic cyc(input string tag, input logic r, input logic s, input logic p,
                     input logic b, input logic [CW-1:0] len);
    exp_t e;
    rst_n    = r;
    start    = s;
    pause    = p;
    beat     = b;
    song_len = len;
    if (!r || s) m_blk = 0;
    else if (m_state == 1 || m_state == 2) m_blk = (m_blk + 1) % (1 << (BD + 1));
    if (!r) begin
      m_state = 0;
      m_cnt   = 0;
    end else if (s) begin
      m_state = 1;
      m_cnt   = 0;
      m_len   = (int'(len) < N) ? N : int'(len);
    end else if (m_state == 1) begin
      if (p) m_state = 2;
      else if (b) begin
        m_cnt++;
        if (m_cnt == m_len) m_state = 3;
      end
    end else if (m_state == 2) begin
      if (!p) m_state = 1;
    end
    e.prog = model_prog();
    e.cnt  = CW'(m_cnt);
    e.busy = (m_state == 1 || m_state == 2);
    e.done = (m_state == 3);
    q_exp.push_back(e);
    @(posedge clk);
    #1;
    e = q_exp.pop_front();
    check({tag, ".prog"}, 32'(prog), 32'(e.prog));
    check({tag, ".cnt"},  32'(beat_cnt), 32'(e.cnt));
    check({tag, ".busy"}, 32'(busy), 32'(e.busy));
    check({tag, ".done"}, 32'(done), 32'(e.done));
  endtask

  task automatic beats(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b1, 1'b0, 1'b0, 1'b1, '0);
  endtask

  task automatic idle(input string tag, input int n, input logic p);
    for (int i = 0; i < n; i++) cyc(tag, 1'b1, 1'b0, p, 1'b0, '0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pause = 1'b0; beat = 1'b0; song_len = '0;
    @(posedge clk); #1;
    cyc("rst", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    cyc("rst", 1'b0, 1'b1, 1'b1, 1'b1, 8'd50);
    check("rst_prog", 32'(prog), 32'h0);
    idle("idle_ign", 2, 1'b1);
    beats("idle_beat", 2);

    cyc("t1_start", 1'b1, 1'b1, 1'b0, 1'b0, 8'd90);
    check("t1_prog0", 32'(prog), 32'h001);
    beats("t1", 9);
    check("t1_b9", 32'(prog), 32'h003);
    beats("t1", 36);
    check("t1_b45", 32'(prog), 32'h03F);
    beats("t1", 45);
    check("t1_b90_prog", 32'(prog), 32'h3FF);
    check("t1_b90_done", 32'(done), 32'd1);
    check("t1_b90_busy", 32'(busy), 32'd0);
    check("t1_b90_cnt", 32'(beat_cnt), 32'd90);

    cyc("t2_start", 1'b1, 1'b1, 1'b0, 1'b0, 8'd4);
    beats("t2", 9);
    check("t2_b9", 32'(prog), 32'h3FF);
    check("t2_b9_done", 32'(done), 32'd0);
    beats("t2", 1);
    check("t2_b10_done", 32'(done), 32'd1);
    beats("t2_extra", 1);
    check("t2_b11_cnt", 32'(beat_cnt), 32'd10);

    cyc("t2z_start", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    beats("t2z", 3);

    cyc("t3_start", 1'b1, 1'b1, 1'b0, 1'b0, 8'd20);
    beats("t3", 5);
    for (int i = 0; i < 3; i++) cyc("t3_pb", 1'b1, 1'b0, 1'b1, 1'b1, '0);
    check("t3_hold_cnt", 32'(beat_cnt), 32'd5);
    check("t3_hold_busy", 32'(busy), 32'd1);
    idle("t3_rel", 1, 1'b0);
    beats("t3", 1);
    check("t3_cnt6", 32'(beat_cnt), 32'd6);

    cyc("t4_start", 1'b1, 1'b1, 1'b0, 1'b0, 8'd100);
    beats("t4", 30);
    cyc("t4_sb", 1'b1, 1'b1, 1'b0, 1'b1, 8'd100);
    check("t4_cnt", 32'(beat_cnt), 32'd0);
    check("t4_prog", 32'(prog), 32'h001);
    check("t4_busy", 32'(busy), 32'd1);

    beats("t5", 40);
    check("t5_cnt40", 32'(beat_cnt), 32'd40);
    cyc("t5_rst", 1'b0, 1'b0, 1'b0, 1'b1, 8'd100);
    check("t5_prog", 32'(prog), 32'h0);
    check("t5_busy", 32'(busy), 32'd0);
    beats("t5_post", 1);
    check("t5_post_cnt", 32'(beat_cnt), 32'd0);

    cyc("t6_start", 1'b1, 1'b1, 1'b0, 1'b0, 8'd10);
    beats("t6", 2);
    idle("t6_play", 8, 1'b0);
`ifndef SONG_PROGRESS_BLINK_EN
    check("t6_steady", 32'(prog), 32'h007);
`endif
    idle("t6_pause", 8, 1'b1);
    cyc("t6_restart", 1'b1, 1'b1, 1'b1, 1'b0, 8'd30);
    idle("t6_repause", 3, 1'b1);
    idle("t6_resume", 2, 1'b0);
    beats("t6_tail", 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
